red_pitaya_filter_cfg: RTL and testbench

RED_PITAYA_FILTER_CFG -- requirements
Module: red_pitaya_filter_cfg

---
 rtl/red_pitaya_filter_pkg.sv | 30 +++
 rtl/red_pitaya_filter_settle_timer.sv | 33 +++
 rtl/red_pitaya_filter_cfg.sv | 143 ++++++++++++++
 tb/tb_red_pitaya_filter_cfg.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/red_pitaya_filter_pkg.sv
// Shared definitions for the filter configuration block and the filter cascade:
// stage byte layout, FSM state type and small elaboration-time helpers.
package red_pitaya_filter_pkg;

   localparam int unsigned CFG_ON_BIT    = 7;
   localparam int unsigned CFG_HP_BIT    = 6;
   localparam int unsigned CFG_SHIFT_LSB = 0;
   localparam int unsigned STAGE_BITS    = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SCAN   = 2'd1,
      ST_SETTLE = 2'd2
   } filt_state_e;

   // Width holding 15 << (2^shiftbits - 1) without overflow.
   function automatic int unsigned settle_cnt_width(input int unsigned shiftbits);
      return 3 + (1 << shiftbits);
   endfunction

   // Bits of a stage byte that are stored; unused shift bits read back as 0.
   function automatic logic [7:0] cfg_keep_mask(input int unsigned shiftbits);
      logic [7:0] m;
      m = 8'(((1 << shiftbits) - 1) << CFG_SHIFT_LSB)
        | 8'(1 << CFG_ON_BIT)
        | 8'(1 << CFG_HP_BIT);
      return m;
   endfunction

endpackage

// File: rtl/red_pitaya_filter_settle_timer.sv
// Settle down-counter: loads a value, decrements on request, flags zero.
module red_pitaya_filter_settle_timer #(
   parameter int unsigned WIDTH = 19
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   // Load has priority over decrement; the count never wraps below zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - WIDTH'(1);
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/red_pitaya_filter_cfg.sv
// Filter cascade configuration: shadow register per stage, commit into the
// active word, then scan the active stages to derive a settling time.
module red_pitaya_filter_cfg
   import red_pitaya_filter_pkg::*;
#(
   parameter int unsigned STAGES      = 4,
   parameter int unsigned SHIFTBITS   = 4,
   parameter int unsigned SETTLE_TAUS = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        wr_valid_i,
   input  logic [1:0]  wr_stage_i,
   input  logic [7:0]  wr_cfg_i,
   output logic        wr_err_o,
   input  logic        commit_valid_i,
   output logic        commit_ready_o,
   output logic [31:0] set_filter_o,
   output logic [31:0] shadow_o,
   output logic        settled_o
);

   localparam int unsigned CNT_W    = settle_cnt_width(SHIFTBITS);
   localparam logic [7:0]  CFG_MASK = cfg_keep_mask(SHIFTBITS);

   filt_state_e                      state_q, state_d;
   logic [3:0][STAGE_BITS-1:0]       shadow_q, shadow_d;
   logic [3:0][STAGE_BITS-1:0]       active_q, active_d;
   logic [1:0]                       idx_q, idx_d;
   logic [SHIFTBITS-1:0]             max_q, max_d;
   logic                             any_q, any_d;
   logic                             settled_q, settled_d;
   logic                             err_q, err_d;

   logic                             commit_ready, commit_acc;
   logic                             wr_in_range, scan_last;
   logic                             cur_on, scan_any;
   logic [SHIFTBITS-1:0]             cur_shift, scan_max;
   logic                             tmr_load, tmr_dec, tmr_zero;
   logic [CNT_W-1:0]                 tmr_load_val;

   assign commit_ready = !rst_i && (state_q != ST_SCAN);
   assign commit_acc   = commit_valid_i && commit_ready;
   assign wr_in_range  = ({30'd0, wr_stage_i} < STAGES);
   assign scan_last    = ({30'd0, idx_q} == (STAGES - 1));
   assign cur_on       = active_q[idx_q][CFG_ON_BIT];
   assign cur_shift    = active_q[idx_q][CFG_SHIFT_LSB +: SHIFTBITS];
   assign scan_any     = any_q | cur_on;
   assign scan_max     = (cur_on && (cur_shift > max_q)) ? cur_shift : max_q;

   // Next state: writes land in the shadow first so a same-cycle commit sees them.
   always_comb begin
      state_d      = state_q;
      shadow_d     = shadow_q;
      active_d     = active_q;
      idx_d        = idx_q;
      max_d        = max_q;
      any_d        = any_q;
      settled_d    = settled_q;
      err_d        = 1'b0;
      tmr_load     = 1'b0;
      tmr_load_val = '0;
      tmr_dec      = 1'b0;

      if (wr_valid_i) begin
         if (wr_in_range) shadow_d[wr_stage_i] = wr_cfg_i & CFG_MASK;
         else             err_d = 1'b1;
      end

      if (commit_acc) begin
         active_d  = shadow_d;
         settled_d = 1'b0;
         idx_d     = '0;
         max_d     = '0;
         any_d     = 1'b0;
         tmr_load  = 1'b1;
         state_d   = ST_SCAN;
      end else begin
         case (state_q)
            ST_SCAN: begin
               any_d = scan_any;
               max_d = scan_max;
               idx_d = idx_q + 2'd1;
               if (scan_last) begin
                  tmr_load     = 1'b1;
                  tmr_load_val = scan_any ? (CNT_W'(SETTLE_TAUS) << scan_max) : '0;
                  state_d      = ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (tmr_zero) begin
                  state_d   = ST_IDLE;
                  settled_d = 1'b1;
               end else begin
                  tmr_dec = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // State and configuration registers; reset bypasses every stage.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         shadow_q  <= '0;
         active_q  <= '0;
         idx_q     <= '0;
         max_q     <= '0;
         any_q     <= 1'b0;
         settled_q <= 1'b1;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         shadow_q  <= shadow_d;
         active_q  <= active_d;
         idx_q     <= idx_d;
         max_q     <= max_d;
         any_q     <= any_d;
         settled_q <= settled_d;
         err_q     <= err_d;
      end
   end

   red_pitaya_filter_settle_timer #(
      .WIDTH (CNT_W)
   ) u_timer (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (tmr_load),
      .load_val_i (tmr_load_val),
      .dec_i      (tmr_dec),
      .zero_o     (tmr_zero)
   );

   assign wr_err_o       = err_q;
   assign commit_ready_o = commit_ready;
   assign set_filter_o   = active_q;
   assign shadow_o       = shadow_q;
   assign settled_o      = settled_q;

endmodule

// File: tb/tb_red_pitaya_filter_cfg.sv
// Bench for red_pitaya_filter_cfg: deadline-based reference model for the
// default instance, a vector table for a two-stage instance, directed corners.
`timescale 1ns/1ps
module tb_red_pitaya_filter_cfg;

   localparam int STG  = 4;
   localparam int TAUS = 4;

   logic clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   logic        rst_i, wr_valid_i, commit_valid_i;
   logic [1:0]  wr_stage_i;
   logic [7:0]  wr_cfg_i;
   logic        wr_err_o, commit_ready_o, settled_o;
   logic [31:0] set_filter_o, shadow_o;

   logic        w2_valid, c2_valid;
   logic [1:0]  w2_stage;
   logic [7:0]  w2_cfg;
   logic        err2, rdy2, settled2;
   logic [31:0] setf2, sh2;

   red_pitaya_filter_cfg dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .wr_valid_i     (wr_valid_i),
      .wr_stage_i     (wr_stage_i),
      .wr_cfg_i       (wr_cfg_i),
      .wr_err_o       (wr_err_o),
      .commit_valid_i (commit_valid_i),
      .commit_ready_o (commit_ready_o),
      .set_filter_o   (set_filter_o),
      .shadow_o       (shadow_o),
      .settled_o      (settled_o)
   );

   red_pitaya_filter_cfg #(
      .STAGES      (2),
      .SHIFTBITS   (4),
      .SETTLE_TAUS (4)
   ) dut2 (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .wr_valid_i     (w2_valid),
      .wr_stage_i     (w2_stage),
      .wr_cfg_i       (w2_cfg),
      .wr_err_o       (err2),
      .commit_valid_i (c2_valid),
      .commit_ready_o (rdy2),
      .set_filter_o   (setf2),
      .shadow_o       (sh2),
      .settled_o      (settled2)
   );

   int total = 0;
   int bad   = 0;

   // Reference model of the default instance: commit edge E, deadline E+STG+1+T.
   longint     nedge = 0;
   logic [7:0] m_sh[4];
   logic [7:0] m_act[4];
   logic       m_err, m_settled;
   longint     m_e = -1000;
   longint     m_settle_at = -1;

   always @(posedge clk_i) begin
      longint n, t;
      int     mx;
      bit     rdy;
      nedge = nedge + 1;
      n = nedge;
      if (rst_i) begin
         for (int j = 0; j < 4; j++) begin
            m_sh[j]  = 8'h00;
            m_act[j] = 8'h00;
         end
         m_err       = 1'b0;
         m_settled   = 1'b1;
         m_e         = -1000;
         m_settle_at = -1;
      end else begin
         rdy   = !(((n - m_e) >= 1) && ((n - m_e) <= STG));
         m_err = wr_valid_i && (int'(wr_stage_i) >= STG);
         if (wr_valid_i && (int'(wr_stage_i) < STG)) m_sh[wr_stage_i] = wr_cfg_i & 8'hCF;
         if (commit_valid_i && rdy) begin
            for (int j = 0; j < 4; j++) m_act[j] = m_sh[j];
            mx = -1;
            for (int j = 0; j < STG; j++)
               if (m_act[j][7] && (int'(m_act[j][3:0]) > mx)) mx = int'(m_act[j][3:0]);
            t = (mx < 0) ? 0 : (longint'(TAUS) << mx);
            m_e         = n;
            m_settled   = 1'b0;
            m_settle_at = n + STG + 1 + t;
         end else if (!m_settled && (n == m_settle_at)) begin
            m_settled = 1'b1;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // One clock edge, then compare the default instance with the model.
   task automatic tick();
      logic exp_rdy;
      @(posedge clk_i);
      #2;
      exp_rdy = !rst_i && !(((nedge + 1 - m_e) >= 1) && ((nedge + 1 - m_e) <= STG));
      chk("m_set_filter", set_filter_o, {m_act[3], m_act[2], m_act[1], m_act[0]});
      chk("m_shadow",     shadow_o,     {m_sh[3], m_sh[2], m_sh[1], m_sh[0]});
      chk("m_settled",    32'(settled_o),      32'(m_settled));
      chk("m_wr_err",     32'(wr_err_o),       32'(m_err));
      chk("m_ready",      32'(commit_ready_o), 32'(exp_rdy));
   endtask

   task automatic count_to_settle(input bit which, input int limit, output int n);
      n = 0;
      while (!(which ? settled2 : settled_o) && (n < limit)) begin
         tick();
         n++;
      end
   endtask

   typedef struct {
      logic        v;
      logic [1:0]  st;
      logic [7:0]  cfg;
      logic [31:0] exp_sh;
      logic        exp_err;
   } vec_t;

   vec_t tbl[7];
   int   n;

   initial begin
      rst_i = 1'b1; wr_valid_i = 1'b0; wr_stage_i = '0; wr_cfg_i = '0; commit_valid_i = 1'b0;
      w2_valid = 1'b0; w2_stage = '0; w2_cfg = '0; c2_valid = 1'b0;

      // Two-stage instance, SHIFTBITS=4: stored byte = cfg & 0xCF.
      tbl[0] = '{1'b1, 2'd0, 8'hFF, 32'h0000_00CF, 1'b0};
      tbl[1] = '{1'b1, 2'd1, 8'h3A, 32'h0000_0ACF, 1'b0};
      tbl[2] = '{1'b1, 2'd3, 8'h81, 32'h0000_0ACF, 1'b1};
      tbl[3] = '{1'b0, 2'd0, 8'h00, 32'h0000_0ACF, 1'b0};
      tbl[4] = '{1'b1, 2'd2, 8'hFF, 32'h0000_0ACF, 1'b1};
      tbl[5] = '{1'b0, 2'd2, 8'hFF, 32'h0000_0ACF, 1'b0};
      tbl[6] = '{1'b1, 2'd0, 8'h45, 32'h0000_0A45, 1'b0};

      tick(); tick();
      rst_i = 1'b0;
      #1;
      chk("ready_after_rst", 32'(commit_ready_o), 32'd1);
      tick();
      chk("rst_set_filter", set_filter_o, 32'h0);
      chk("rst_shadow",     shadow_o,     32'h0);
      chk("rst_settled",    32'(settled_o), 32'd1);
      chk("rst_ready",      32'(commit_ready_o), 32'd1);

      for (int i = 0; i < 7; i++) begin
         w2_valid = tbl[i].v; w2_stage = tbl[i].st; w2_cfg = tbl[i].cfg;
         tick();
         chk("tbl_shadow", sh2, tbl[i].exp_sh);
         chk("tbl_err",    32'(err2), 32'(tbl[i].exp_err));
         chk("tbl_setf",   setf2, 32'h0);
      end
      chk("tbl_ready", 32'(rdy2), 32'd1);

      // Same-cycle write and commit on the two-stage instance.
      w2_valid = 1'b1; w2_stage = 2'd0; w2_cfg = 8'h81; c2_valid = 1'b1;
      tick();
      w2_valid = 1'b0; c2_valid = 1'b0;
      chk("wc_setf",    setf2, 32'h0000_0A81);
      chk("wc_settled", 32'(settled2), 32'd0);
      count_to_settle(1'b1, 50, n);
      chk("wc_settle_time", 32'(n), 32'd11);

      // On, shift 3: T = 32, rises at E+37.
      wr_valid_i = 1'b1; wr_stage_i = 2'd0; wr_cfg_i = 8'h83;
      tick();
      wr_valid_i = 1'b0; commit_valid_i = 1'b1;
      tick();
      commit_valid_i = 1'b0;
      chk("c1_setf",    set_filter_o, 32'h0000_0083);
      chk("c1_settled", 32'(settled_o), 32'd0);
      count_to_settle(1'b0, 100, n);
      chk("c1_settle_time", 32'(n), 32'd37);

      // Only stage1, filter off: T = 0, rises at E+5.
      wr_valid_i = 1'b1; wr_stage_i = 2'd0; wr_cfg_i = 8'h00;
      tick();
      wr_stage_i = 2'd1; wr_cfg_i = 8'h45;
      tick();
      wr_valid_i = 1'b0; commit_valid_i = 1'b1;
      tick();
      commit_valid_i = 1'b0;
      chk("c2_setf", set_filter_o, 32'h0000_4500);
      count_to_settle(1'b0, 100, n);
      chk("c2_settle_time", 32'(n), 32'd5);

      // Shift-15 config, then recommit from SETTLE with commit held through SCAN.
      wr_valid_i = 1'b1; wr_stage_i = 2'd2; wr_cfg_i = 8'h8F;
      tick();
      wr_valid_i = 1'b0; commit_valid_i = 1'b1;
      tick();
      commit_valid_i = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      chk("s15_ready",   32'(commit_ready_o), 32'd1);
      chk("s15_settled", 32'(settled_o), 32'd0);
      wr_valid_i = 1'b1; wr_stage_i = 2'd2; wr_cfg_i = 8'h00; commit_valid_i = 1'b1;
      tick();
      wr_valid_i = 1'b0;
      chk("hold_ready_e", 32'(commit_ready_o), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold_ready_scan", 32'(commit_ready_o), 32'd0);
      end
      tick();
      chk("hold_ready_settle", 32'(commit_ready_o), 32'd1);
      tick();
      commit_valid_i = 1'b0;
      chk("hold_reaccept", 32'(commit_ready_o), 32'd0);
      chk("hold_settled",  32'(settled_o), 32'd0);
      count_to_settle(1'b0, 50, n);
      chk("hold_settle_time", 32'(n), 32'd5);

      // Reset in the middle of a long SETTLE.
      wr_valid_i = 1'b1; wr_stage_i = 2'd2; wr_cfg_i = 8'h8F; commit_valid_i = 1'b1;
      tick();
      wr_valid_i = 1'b0; commit_valid_i = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      rst_i = 1'b1;
      tick();
      chk("mrst_setf",    set_filter_o, 32'h0);
      chk("mrst_shadow",  shadow_o, 32'h0);
      chk("mrst_settled", 32'(settled_o), 32'd1);
      chk("mrst_ready",   32'(commit_ready_o), 32'd0);
      rst_i = 1'b0;
      #1;
      chk("mrst_ready_rel", 32'(commit_ready_o), 32'd1);
      tick();

      // Randomized traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         rst_i          = ($urandom_range(0, 99) == 0);
         wr_valid_i     = $urandom_range(0, 1);
         wr_stage_i     = 2'($urandom);
         wr_cfg_i       = 8'($urandom);
         commit_valid_i = ($urandom_range(0, 7) == 0);
         tick();
      end
      rst_i = 1'b0; wr_valid_i = 1'b0; commit_valid_i = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
